// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS core.
// Defines the control bundle layout and the register-zero and bubble encodings.
package mips_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 10;

    localparam int CTRL_REGDST   = 9;
    localparam int CTRL_ALUSRC   = 8;
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_JUMP     = 0;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic [CW-1:0] BUBBLE   = {CW{1'b0}};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
// Purely combinational; reset masks the stall request.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int AW_P = AW
) (
    input  logic            RST,
    input  logic            memread_ex,
    input  logic [AW_P-1:0] rt_ex,
    input  logic [AW_P-1:0] rs_id,
    input  logic [AW_P-1:0] rt_id,
    output logic            stall
);

    logic rt_nz;
    logic hit;

    always_comb begin
        rt_nz = (rt_ex != {AW_P{1'b0}});
        hit   = (rt_ex == rs_id) || (rt_ex == rt_id);
        stall = !RST && memread_ex && rt_nz && hit;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through bypass and load-use stall.
// Also keeps a saturating stall-cycle counter for performance debug.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW_P = DW,
    parameter int AW_P = AW,
    parameter int CW_P = CW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [31:0]     Instr_ID,
    input  logic [DW_P-1:0] PC4_ID,
    input  logic [CW_P-1:0] Ctrl_ID,
    input  logic [DW_P-1:0] ReadData1,
    input  logic [DW_P-1:0] ReadData2,
    input  logic            RegWrite_WB,
    input  logic [AW_P-1:0] WriteReg_WB,
    input  logic [DW_P-1:0] WriteData_WB,
    input  logic            Flush,
    output logic            Stall,
    output logic [CW_P-1:0] Ctrl_EX,
    output logic [DW_P-1:0] RD1_EX,
    output logic [DW_P-1:0] RD2_EX,
    output logic [DW_P-1:0] Imm_EX,
    output logic [DW_P-1:0] PC4_EX,
    output logic [AW_P-1:0] Rs_EX,
    output logic [AW_P-1:0] Rt_EX,
    output logic [AW_P-1:0] Rd_EX,
    output logic [31:0]     StallCount
);

    logic [AW_P-1:0] rs_id;
    logic [AW_P-1:0] rt_id;
    logic [AW_P-1:0] rd_id;
    logic [DW_P-1:0] op1;
    logic [DW_P-1:0] op2;
    logic [DW_P-1:0] imm_id;
    logic            wb_ok;
    logic            unused_opc;

    assign rs_id      = Instr_ID[25:21];
    assign rt_id      = Instr_ID[20:16];
    assign rd_id      = Instr_ID[15:11];
    assign unused_opc = ^Instr_ID[31:26];

    // Regfile reads are stale when WB writes the same register this cycle.
    always_comb begin
        wb_ok  = RegWrite_WB && (WriteReg_WB != REG_ZERO);
        op1    = ReadData1;
        op2    = ReadData2;
        if (wb_ok && (WriteReg_WB == rs_id))
            op1 = WriteData_WB;
        if (wb_ok && (WriteReg_WB == rt_id))
            op2 = WriteData_WB;
        imm_id = {{(DW_P-16){Instr_ID[15]}}, Instr_ID[15:0]};
    end

    hazard_detect #(
        .AW_P(AW_P)
    ) u_hazard (
        .RST       (RST),
        .memread_ex(Ctrl_EX[CTRL_MEMREAD]),
        .rt_ex     (Rt_EX),
        .rs_id     (rs_id),
        .rt_id     (rt_id),
        .stall     (Stall)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            Ctrl_EX    <= BUBBLE;
            RD1_EX     <= '0;
            RD2_EX     <= '0;
            Imm_EX     <= '0;
            PC4_EX     <= '0;
            Rs_EX      <= '0;
            Rt_EX      <= '0;
            Rd_EX      <= '0;
            StallCount <= '0;
        end else begin
            Ctrl_EX <= (Flush || Stall) ? BUBBLE : Ctrl_ID;
            RD1_EX  <= op1;
            RD2_EX  <= op2;
            Imm_EX  <= imm_id;
            PC4_EX  <= PC4_ID;
            Rs_EX   <= rs_id;
            Rt_EX   <= rt_id;
            Rd_EX   <= rd_id;
            if (Stall && !(&StallCount))
                StallCount <= StallCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage.
// Outputs are compared against an in-bench reference model of the ID/EX rules.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Instr_ID;
    logic [31:0] PC4_ID;
    logic [9:0]  Ctrl_ID;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        RegWrite_WB;
    logic [4:0]  WriteReg_WB;
    logic [31:0] WriteData_WB;
    logic        Flush;
    logic        Stall;
    logic [9:0]  Ctrl_EX;
    logic [31:0] RD1_EX, RD2_EX, Imm_EX, PC4_EX;
    logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
    logic [31:0] StallCount;

    always #5 CLK = ~CLK;

    id_ex_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .Instr_ID    (Instr_ID),
        .PC4_ID      (PC4_ID),
        .Ctrl_ID     (Ctrl_ID),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .RegWrite_WB (RegWrite_WB),
        .WriteReg_WB (WriteReg_WB),
        .WriteData_WB(WriteData_WB),
        .Flush       (Flush),
        .Stall       (Stall),
        .Ctrl_EX     (Ctrl_EX),
        .RD1_EX      (RD1_EX),
        .RD2_EX      (RD2_EX),
        .Imm_EX      (Imm_EX),
        .PC4_EX      (PC4_EX),
        .Rs_EX       (Rs_EX),
        .Rt_EX       (Rt_EX),
        .Rd_EX       (Rd_EX),
        .StallCount  (StallCount)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0]  m_ctrl = '0;
    logic [31:0] m_rd1 = '0, m_rd2 = '0, m_imm = '0, m_pc4 = '0;
    logic [4:0]  m_rs = '0, m_rt = '0, m_rd = '0;
    logic [31:0] m_cnt = '0;
    bit          m_dv = 1'b1;
    bit          last_es;

    localparam logic [31:0] LW_T1  = 32'h8D090000;
    localparam logic [31:0] LW_Z   = 32'h8D000000;
    localparam logic [31:0] ADD_T2 = 32'h012B5020;
    localparam logic [31:0] ADD_Z  = 32'h000B5020;
    localparam logic [9:0]  C_LW   = 10'h1E0;
    localparam logic [9:0]  C_R    = 10'h244;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit rst, input bit flush,
                        input logic [31:0] ins, input logic [31:0] pc4,
                        input logic [9:0] ctrl,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input bit rw, input logic [4:0] wr,
                        input logic [31:0] wd);
        bit          es;
        logic [31:0] o1, o2;
        @(negedge CLK);
        RST = rst; Flush = flush; Instr_ID = ins; PC4_ID = pc4;
        Ctrl_ID = ctrl; ReadData1 = r1; ReadData2 = r2;
        RegWrite_WB = rw; WriteReg_WB = wr; WriteData_WB = wd;
        #1;
        // A load in EX whose target is read by the ID instruction.
        es = !rst && (m_ctrl[5] == 1'b1) && (m_rt != 0) &&
             (m_rt == ins[25:21] || m_rt == ins[20:16]);
        last_es = es;
        chk("stall", {31'b0, Stall}, {31'b0, es});
        o1 = (rw && wr != 0 && wr == ins[25:21]) ? wd : r1;
        o2 = (rw && wr != 0 && wr == ins[20:16]) ? wd : r2;
        if (rst) begin
            m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc4 = '0;
            m_rs = '0; m_rt = '0; m_rd = '0; m_cnt = '0; m_dv = 1'b1;
        end else begin
            if (es && m_cnt != 32'hFFFFFFFF)
                m_cnt = m_cnt + 1;
            m_ctrl = (flush || es) ? 10'd0 : ctrl;
            m_rd1 = o1;
            m_rd2 = o2;
            m_imm = ins[15] ? (32'hFFFF0000 | {16'd0, ins[15:0]})
                            : {16'd0, ins[15:0]};
            m_pc4 = pc4;
            m_rs = ins[25:21];
            m_rt = ins[20:16];
            m_rd = ins[15:11];
            m_dv = !flush;
        end
        @(posedge CLK);
        #1;
        chk("ctrl", {22'd0, Ctrl_EX}, {22'd0, m_ctrl});
        chk("cnt", StallCount, m_cnt);
        if (m_dv) begin
            chk("rd1", RD1_EX, m_rd1);
            chk("rd2", RD2_EX, m_rd2);
            chk("imm", Imm_EX, m_imm);
            chk("pc4", PC4_EX, m_pc4);
            chk("rs", {27'd0, Rs_EX}, {27'd0, m_rs});
            chk("rt", {27'd0, Rt_EX}, {27'd0, m_rt});
            chk("rd", {27'd0, Rd_EX}, {27'd0, m_rd});
        end
    endtask

    task automatic rnd_tick(input bit rst, input bit flush);
        logic [31:0] ins;
        ins = $urandom;
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        tick(rst, flush, ins, $urandom, 10'($urandom),
             $urandom, $urandom, 1'($urandom),
             5'($urandom_range(0, 3)), $urandom);
    endtask

    initial begin
        logic [31:0] c0;

        rnd_tick(1'b1, 1'b0);
        rnd_tick(1'b1, 1'($urandom));
        chk("rst_ctrl", {22'd0, Ctrl_EX}, 32'd0);
        chk("rst_rd1", RD1_EX, 32'd0);
        chk("rst_cnt", StallCount, 32'd0);

        tick(0, 0, 32'h2109FFFC, 32'h104, C_R, 32'd7, 32'd3, 0, 5'd0, 0);
        chk("addi_rd1", RD1_EX, 32'd7);
        chk("addi_imm", Imm_EX, 32'hFFFFFFFC);
        chk("addi_rt", {27'd0, Rt_EX}, 32'd9);

        tick(0, 0, 32'h01000000, 0, C_R, 32'd0, 0, 1, 5'd8, 32'h1234);
        chk("byp_rd1", RD1_EX, 32'h1234);
        tick(0, 0, 32'h00000000, 0, C_R, 32'h55, 0, 1, 5'd0, 32'h1234);
        chk("byp_z", RD1_EX, 32'h55);

        c0 = StallCount;
        tick(0, 0, LW_T1, 32'h200, C_LW, 32'h10, 32'h20, 0, 0, 0);
        tick(0, 0, ADD_T2, 32'h204, C_R, 32'h1, 32'h2, 0, 0, 0);
        chk("lu_stall", {31'b0, last_es}, 32'd1);
        chk("lu_bubble", {22'd0, Ctrl_EX}, 32'd0);
        tick(0, 0, ADD_T2, 32'h204, C_R, 32'h1, 32'h2, 0, 0, 0);
        chk("lu_nostall", {31'b0, last_es}, 32'd0);
        chk("lu_add", {22'd0, Ctrl_EX}, {22'd0, C_R});
        chk("lu_cnt", StallCount, c0 + 32'd1);

        tick(0, 0, LW_Z, 32'h300, C_LW, 0, 0, 0, 0, 0);
        tick(0, 0, ADD_Z, 32'h304, C_R, 0, 0, 0, 0, 0);
        chk("lw0_ctrl", {22'd0, Ctrl_EX}, {22'd0, C_R});

        c0 = StallCount;
        tick(0, 0, LW_T1, 32'h400, C_LW, 0, 0, 0, 0, 0);
        tick(0, 1, ADD_T2, 32'h404, C_R, 0, 0, 0, 0, 0);
        chk("fs_ctrl", {22'd0, Ctrl_EX}, 32'd0);
        chk("fs_cnt", StallCount, c0 + 32'd1);
        tick(0, 1, ADD_T2, 32'h408, C_R, 0, 0, 0, 0, 0);
        chk("f_cnt", StallCount, c0 + 32'd1);

        force dut.StallCount = 32'hFFFFFFFE;
        #1;
        release dut.StallCount;
        m_cnt = 32'hFFFFFFFE;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, LW_T1, 32'h500, C_LW, 0, 0, 0, 0, 0);
            tick(0, 0, ADD_T2, 32'h504, C_R, 0, 0, 0, 0, 0);
        end
        chk("sat", StallCount, 32'hFFFFFFFF);

        for (int i = 0; i < 400; i++)
            rnd_tick(($urandom_range(0, 49) == 0),
                     ($urandom_range(0, 7) == 0));

        tick(0, 0, LW_T1, 0, C_LW, 0, 0, 0, 0, 0);
        rnd_tick(1'b1, 1'b0);
        chk("rst_mid", StallCount, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
